// File: rtl/exec_muldiv_ctrl.sv
// Iterative 8-bit multiply/divide sequencer beside the EX-stage ALU: shift-add MUL/MULH,
// restoring DIV/REM, 8 RUN cycles. Optional macro MULDIV_EARLY_OUT_EN shortens trivial ops.
`timescale 1ns/1ps
module exec_muldiv_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [1:0] op,
  input  logic       is_unsigned,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       flush,
  output logic       stall,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      r_state;
  logic [1:0]  r_op;
  logic        r_neg;
  logic        r_bz;
  logic [7:0]  r_a_raw;
  logic [7:0]  r_mcand;
  logic [7:0]  r_shift;
  logic [3:0]  r_cnt;
  logic [15:0] r_acc;
  logic        r_busy;
  logic        r_done;
  logic        r_dbz;
  logic [7:0]  r_result;
`ifdef MULDIV_EARLY_OUT_EN
  logic        r_early;
`endif

  logic [7:0]  w_a_mag, w_b_mag;
  logic        w_neg;
  logic [8:0]  w_add;
  logic [8:0]  w_rem_sh;
  logic [7:0]  w_sub;
  logic        w_ge;
  logic [15:0] w_acc_next;
  logic [15:0] w_prod;
  logic [7:0]  w_quo, w_rem;
  logic [7:0]  w_res;
  logic        w_last;

  assign w_a_mag = (!is_unsigned && a[7]) ? (8'd0 - a) : a;
  assign w_b_mag = (!is_unsigned && b[7]) ? (8'd0 - b) : b;
  // REM takes the dividend's sign; the other ops take the product/quotient sign
  assign w_neg   = !is_unsigned && ((op == 2'b11) ? a[7] : (a[7] ^ b[7]));

  assign stall       = ((r_state == S_IDLE) && start) || (r_state == S_RUN);
  assign busy        = r_busy;
  assign done        = r_done;
  assign result      = r_result;
  assign div_by_zero = r_dbz;

  always_comb begin
    w_add      = {1'b0, r_acc[15:8]} + (r_shift[0] ? {1'b0, r_mcand} : 9'd0);
    w_rem_sh   = {r_acc[15:8], r_shift[7]};
    w_ge       = (w_rem_sh >= {1'b0, r_mcand});
    // on success the true difference is below the divisor, so 8 bits suffice
    w_sub      = w_rem_sh[7:0] - r_mcand;
    w_acc_next = {w_add, r_acc[7:1]};
    if (r_op[1])
      w_acc_next = w_ge ? {w_sub, r_acc[6:0], 1'b1} : {w_rem_sh[7:0], r_acc[6:0], 1'b0};
    w_prod     = r_neg ? (16'd0 - w_acc_next) : w_acc_next;
    w_quo      = r_neg ? (8'd0 - w_acc_next[7:0])  : w_acc_next[7:0];
    w_rem      = r_neg ? (8'd0 - w_acc_next[15:8]) : w_acc_next[15:8];
    unique case (r_op)
      2'b00:   w_res = w_prod[7:0];
      2'b01:   w_res = w_prod[15:8];
      2'b10:   w_res = r_bz ? 8'hFF : w_quo;
      default: w_res = r_bz ? r_a_raw : w_rem;
    endcase
    w_last     = (r_cnt == 4'd7);
`ifdef MULDIV_EARLY_OUT_EN
    if (r_early) w_last = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_op     <= 2'b00;
      r_neg    <= 1'b0;
      r_bz     <= 1'b0;
      r_a_raw  <= 8'd0;
      r_mcand  <= 8'd0;
      r_shift  <= 8'd0;
      r_cnt    <= 4'd0;
      r_acc    <= 16'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_result <= 8'd0;
`ifdef MULDIV_EARLY_OUT_EN
      r_early  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start && !flush) begin
            r_op    <= op;
            r_neg   <= w_neg;
            r_bz    <= (b == 8'd0);
            r_a_raw <= a;
            // MUL: add |a|, shift |b| right; DIV: shift |a| in from the top, subtract |b|
            r_mcand <= op[1] ? w_b_mag : w_a_mag;
            r_shift <= op[1] ? w_a_mag : w_b_mag;
            r_cnt   <= 4'd0;
            r_acc   <= 16'd0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
`ifdef MULDIV_EARLY_OUT_EN
            r_early <= op[1] ? (b == 8'd0) : ((a == 8'd0) || (b == 8'd0));
`endif
          end
        end
        S_RUN: begin
          if (flush) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_acc   <= w_acc_next;
            r_shift <= r_op[1] ? {r_shift[6:0], 1'b0} : {1'b0, r_shift[7:1]};
            r_cnt   <= r_cnt + 4'd1;
            if (w_last) begin
              r_result <= w_res;
              r_done   <= 1'b1;
              r_dbz    <= r_op[1] && r_bz;
              r_state  <= S_DONE;
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_muldiv_ctrl.sv
// Randomized self-checking bench for exec_muldiv_ctrl against an arithmetic reference model.
`timescale 1ns/1ps
module tb_exec_muldiv_ctrl;

  logic       clk = 1'b0;
  logic       reset_n, start, flush, is_unsigned;
  logic [1:0] op;
  logic [7:0] a, b;
  logic       stall, busy, done, div_by_zero;
  logic [7:0] result;

  int n_chk  = 0;
  int n_fail = 0;

  exec_muldiv_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .is_unsigned(is_unsigned),
    .a(a), .b(b), .flush(flush), .stall(stall), .busy(busy), .done(done),
    .result(result), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // {div_by_zero, result} from plain integer arithmetic
  function automatic logic [8:0] model(input logic [1:0] o, input logic u,
                                       input logic [7:0] x, input logic [7:0] y);
    int sx, sy, r;
    logic [31:0] v;
    sx = u ? int'({24'd0, x}) : int'({{24{x[7]}}, x});
    sy = u ? int'({24'd0, y}) : int'({{24{y[7]}}, y});
    if (!o[1]) begin
      v = sx * sy;
      return {1'b0, o[0] ? v[15:8] : v[7:0]};
    end
    if (y == 8'd0) return {1'b1, o[0] ? x : 8'hFF};
    r = o[0] ? (sx % sy) : (sx / sy);
    v = r;
    return {1'b0, v[7:0]};
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
`ifdef MULDIV_EARLY_OUT_EN
    if (o[1] ? (y == 8'd0) : ((x == 8'd0) || (y == 8'd0))) return 2;
`endif
    return 9;
  endfunction

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 7))
      0: return 8'h00;
      1: return 8'h80;
      2: return 8'hFF;
      3: return 8'h01;
      default: return 8'($urandom);
    endcase
  endfunction

  // Entered and left just after a falling edge.
  task automatic run_op(input string tag, input logic [1:0] o, input logic u,
                        input logic [7:0] x, input logic [7:0] y, input bit junk);
    logic [8:0] m;
    int lat, c;
    m = model(o, u, x, y);
    lat = exp_lat(o, x, y);
    op = o; is_unsigned = u; a = x; b = y; start = 1'b1;
    #1 chk({tag, "_stall_start"}, stall, 1);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    c = 1;
    chk({tag, "_busy"}, busy, 1);
    while (!done && c < 20) begin
      if (junk && lat == 9 && c < 8) begin
        start = 1'($urandom_range(0, 1));
        op = 2'($urandom); a = 8'($urandom); b = 8'($urandom); is_unsigned = 1'($urandom);
      end else start = 1'b0;
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, c, lat);
    chk({tag, "_result"}, result, m[7:0]);
    chk({tag, "_dbz"}, div_by_zero, m[8]);
    chk({tag, "_stall_done"}, stall, 0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {done, busy, div_by_zero}, 3'b000);
    chk({tag, "_hold"}, result, m[7:0]);
  endtask

  initial begin
    int seen;
    reset_n = 1'b0; start = 1'b0; flush = 1'b0; is_unsigned = 1'b0;
    op = 2'b00; a = 8'd0; b = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst_state", {busy, done, div_by_zero, stall, result}, 12'h000);
    reset_n = 1'b1;
    @(negedge clk);

    run_op("mul_s",   2'b00, 1'b0, 8'hFD, 8'h05, 1'b0);
    chk("mul_s_tp", result, 8'hF1);
    run_op("mulh_s",  2'b01, 1'b0, 8'hFD, 8'h05, 1'b0);
    chk("mulh_s_tp", result, 8'hFF);
    run_op("mulh_u",  2'b01, 1'b1, 8'hC8, 8'hC8, 1'b0);
    chk("mulh_u_tp", result, 8'h9C);
    run_op("mul_u",   2'b00, 1'b1, 8'hC8, 8'hC8, 1'b0);
    chk("mul_u_tp", result, 8'h40);
    run_op("div_s",   2'b10, 1'b0, 8'hF9, 8'h02, 1'b0);
    chk("div_s_tp", result, 8'hFD);
    run_op("rem_s",   2'b11, 1'b0, 8'hF9, 8'h02, 1'b0);
    chk("rem_s_tp", result, 8'hFF);
    run_op("div_ovf", 2'b10, 1'b0, 8'h80, 8'hFF, 1'b0);
    chk("div_ovf_tp", result, 8'h80);
    run_op("rem_ovf", 2'b11, 1'b0, 8'h80, 8'hFF, 1'b0);
    chk("rem_ovf_tp", result, 8'h00);
    run_op("div_z",   2'b10, 1'b0, 8'h2A, 8'h00, 1'b0);
    chk("div_z_tp", {div_by_zero, result}, 9'h0FF);
    run_op("rem_z",   2'b11, 1'b1, 8'h2A, 8'h00, 1'b0);
    chk("rem_z_tp", result, 8'h2A);
    run_op("mul_zero", 2'b01, 1'b0, 8'h00, 8'h93, 1'b0);

    // flush with start in IDLE: nothing accepted
    start = 1'b1; flush = 1'b1; op = 2'b00; a = 8'h11; b = 8'h22;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_idle_busy", busy, 0);
    seen = 0;
    repeat (10) begin @(negedge clk); if (done) seen++; end
    chk("flush_idle_nodone", seen, 0);

    // flush in RUN at cycle 4
    op = 2'b00; is_unsigned = 1'b1; a = 8'h37; b = 8'h59; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    repeat (3) begin @(negedge clk); if (done) seen++; end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    if (done) seen++;
    chk("flush_run_state", {busy, stall, done}, 3'b000);
    run_op("after_flush", 2'b00, 1'b1, 8'h37, 8'h59, 1'b0);
    chk("flush_run_nodone", seen, 0);

    // asynchronous reset at cycle 6 of a DIV
    op = 2'b10; is_unsigned = 1'b1; a = 8'h64; b = 8'h07; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk("async_rst", {busy, stall, done, div_by_zero, result}, 12'h000);
    @(negedge clk);
    reset_n = 1'b1;
    run_op("after_rst", 2'b10, 1'b1, 8'h64, 8'h07, 1'b0);

    for (int i = 0; i < 50; i++)
      run_op("rand", 2'($urandom), 1'($urandom), pick(), pick(), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
